execute_stage: RTL

Execute stage of the ARM_Calculator datapath, directly upstream of the Mem stage. It accepts decoded operations with a valid/ready handshake and computes single-cycle ALU results or iterative 32-cycle MUL/UDIV results. It then presents ALUResult, WD, MemWrite and MemtoReg, plus writeback control, from an output register that feeds Mem.

---
 rtl/execute_if.sv | 42 ++++
 rtl/execute_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_if.sv
// Handshake and data bundle between the decode side, the execute stage and Mem.
interface execute_if #(
   parameter int WIDTH = 32
);
   // Upstream operation channel
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       Op;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [WIDTH-1:0] WD_in;
   logic             MemWrite_in;
   logic             MemtoReg_in;
   logic             RegWrite_in;
   logic [3:0]       WA3_in;

   // Downstream result channel into Mem
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALUResult;
   logic [WIDTH-1:0] WD;
   logic             MemWrite;
   logic             MemtoReg;
   logic             RegWrite;
   logic [3:0]       WA3;
   logic [3:0]       Flags;
   logic             busy;

   // Environment side: issues operations and consumes results
   modport master (
      output in_valid, Op, SrcA, SrcB, WD_in, MemWrite_in, MemtoReg_in, RegWrite_in, WA3_in,
      output out_ready,
      input  in_ready, out_valid, ALUResult, WD, MemWrite, MemtoReg, RegWrite, WA3, Flags, busy
   );

   // Execute stage side
   modport slave (
      input  in_valid, Op, SrcA, SrcB, WD_in, MemWrite_in, MemtoReg_in, RegWrite_in, WA3_in,
      input  out_ready,
      output in_ready, out_valid, ALUResult, WD, MemWrite, MemtoReg, RegWrite, WA3, Flags, busy
   );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU ops plus iterative 32-cycle MUL / UDIV,
// results presented to Mem from a valid/ready output register.
module execute_stage #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   execute_if.slave bus
);
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_ORR  = 3'd3;
   localparam logic [2:0] OP_EOR  = 3'd4;
   localparam logic [2:0] OP_MOV  = 3'd5;
   localparam logic [2:0] OP_MUL  = 3'd6;
   localparam logic [2:0] OP_UDIV = 3'd7;

   typedef enum logic [1:0] {IDLE, BUSY, WAIT} state_e;

   // Sequencer and iterative-unit holding registers
   state_e           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, rem_q, rem_d;
   logic [WIDTH-1:0] wd_h_q, wd_h_d;
   logic             mw_h_q, mw_h_d, mr_h_q, mr_h_d, rw_h_q, rw_h_d;
   logic [3:0]       wa3_h_q, wa3_h_d;

   // Output register feeding Mem
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d, wd_q, wd_d;
   logic             mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
   logic             reg_write_q, reg_write_d;
   logic [3:0]       wa3_q, wa3_d, flags_q, flags_d;
   logic             busy_q, busy_d;

   logic             out_free, in_ready;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;
   logic [WIDTH-1:0] mul_next, rem_next, quo_next, iter_res;
   logic [WIDTH:0]   rem_sh, rem_diff;
   logic             q_bit;
   logic             load, ld_c, ld_v, ld_mw, ld_mr, ld_rw;
   logic [WIDTH-1:0] ld_res, ld_wd;
   logic [3:0]       ld_wa3;

   assign out_free = !out_valid_q || bus.out_ready;
   assign in_ready = (state_q == IDLE) && out_free;

   // Single-cycle ALU on the live operands, with NZCV carry/overflow terms
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      sum     = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.Op)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != bus.SrcA[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = bus.SrcA - bus.SrcB;
            alu_c   = bus.SrcA >= bus.SrcB;
            alu_v   = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) && (alu_res[WIDTH-1] != bus.SrcA[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.SrcA & bus.SrcB;
         OP_ORR:  alu_res = bus.SrcA | bus.SrcB;
         OP_EOR:  alu_res = bus.SrcA ^ bus.SrcB;
         OP_MOV:  alu_res = bus.SrcB;
         default: alu_res = '0;
      endcase
   end

   // One iteration of shift-add multiply (LSB first) or restoring divide (MSB first)
   always_comb begin
      mul_next = b_q[0] ? acc_q + a_q : acc_q;
      rem_sh   = {rem_q, a_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      // A zero divisor never sets a quotient bit, so the quotient comes out as 0.
      q_bit    = (b_q != '0) && !rem_diff[WIDTH];
      rem_next = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_next = {a_q[WIDTH-2:0], q_bit};
      iter_res = is_div_q ? quo_next : mul_next;
   end

   // Next-state: accept, iterate, complete or wait, and output register update
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      rem_d       = rem_q;
      wd_h_d      = wd_h_q;
      mw_h_d      = mw_h_q;
      mr_h_d      = mr_h_q;
      rw_h_d      = rw_h_q;
      wa3_h_d     = wa3_h_q;
      load        = 1'b0;
      ld_res      = acc_q;
      ld_c        = 1'b0;
      ld_v        = 1'b0;
      ld_wd       = wd_h_q;
      ld_mw       = mw_h_q;
      ld_mr       = mr_h_q;
      ld_rw       = rw_h_q;
      ld_wa3      = wa3_h_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready) begin
               if (bus.Op == OP_MUL || bus.Op == OP_UDIV) begin
                  is_div_d = (bus.Op == OP_UDIV);
                  a_d      = bus.SrcA;
                  b_d      = bus.SrcB;
                  acc_d    = '0;
                  rem_d    = '0;
                  cnt_d    = '0;
                  wd_h_d   = bus.WD_in;
                  mw_h_d   = bus.MemWrite_in;
                  mr_h_d   = bus.MemtoReg_in;
                  rw_h_d   = bus.RegWrite_in;
                  wa3_h_d  = bus.WA3_in;
                  state_d  = BUSY;
               end else begin
                  load   = 1'b1;
                  ld_res = alu_res;
                  ld_c   = alu_c;
                  ld_v   = alu_v;
                  ld_wd  = bus.WD_in;
                  ld_mw  = bus.MemWrite_in;
                  ld_mr  = bus.MemtoReg_in;
                  ld_rw  = bus.RegWrite_in;
                  ld_wa3 = bus.WA3_in;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 5'd1;
            if (is_div_q) begin
               a_d   = quo_next;
               rem_d = rem_next;
            end else begin
               acc_d = mul_next;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
            end
            if (cnt_q == 5'd31) begin
               // Park the finished result so WAIT can present it later.
               acc_d = iter_res;
               if (out_free) begin
                  load    = 1'b1;
                  ld_res  = iter_res;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.out_ready) begin
               load    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d  = load ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
      result_d     = load ? ld_res : result_q;
      flags_d      = load ? {ld_res[WIDTH-1], ld_res == '0, ld_c, ld_v} : flags_q;
      wd_d         = load ? ld_wd : wd_q;
      mem_write_d  = load ? ld_mw : mem_write_q;
      mem_to_reg_d = load ? ld_mr : mem_to_reg_q;
      reg_write_d  = load ? ld_rw : reg_write_q;
      wa3_d        = load ? ld_wa3 : wa3_q;
      busy_d       = (state_d != IDLE);
   end

   // State, holding and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the holding registers are reset too; they are few, and a reset mid-operation then leaves nothing stale behind.
         state_q      <= IDLE;
         cnt_q        <= '0;
         is_div_q     <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         acc_q        <= '0;
         rem_q        <= '0;
         wd_h_q       <= '0;
         mw_h_q       <= 1'b0;
         mr_h_q       <= 1'b0;
         rw_h_q       <= 1'b0;
         wa3_h_q      <= '0;
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         wd_q         <= '0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         wa3_q        <= '0;
         flags_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of its peers.
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         is_div_q     <= is_div_d;
         a_q          <= a_d;
         b_q          <= b_d;
         acc_q        <= acc_d;
         rem_q        <= rem_d;
         wd_h_q       <= wd_h_d;
         mw_h_q       <= mw_h_d;
         mr_h_q       <= mr_h_d;
         rw_h_q       <= rw_h_d;
         wa3_h_q      <= wa3_h_d;
         out_valid_q  <= out_valid_d;
         result_q     <= result_d;
         wd_q         <= wd_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         reg_write_q  <= reg_write_d;
         wa3_q        <= wa3_d;
         flags_q      <= flags_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.ALUResult = result_q;
   assign bus.WD        = wd_q;
   // Mem must never see a write strobe from an empty or already-consumed register.
   assign bus.MemWrite  = mem_write_q & out_valid_q;
   assign bus.MemtoReg  = mem_to_reg_q;
   assign bus.RegWrite  = reg_write_q;
   assign bus.WA3       = wa3_q;
   assign bus.Flags     = flags_q;
   assign bus.busy      = busy_q;
endmodule
